fwu_resp_framer: RTL and testbench
==================================

Name: fwu_resp_framer

Overview:
- Store-and-forward response framer that sits directly upstream of the UART byte transmitter.
- Accepts one response packet as a byte stream (valid/ready/last) into an internal buffer.
- Then emits it to the transmitter byte-by-byte as a frame: SOF, LEN, payload, CHK (optional EOF).
- Gives firmware-update logic a framed, checksummed reply path without having to pace bytes itself.

Parameters:
- MAX_LEN, 64, payload buffer depth in bytes; legal 1..255 (LEN is 8 bits).
- SOF_BYTE, 8'hA5, start-of-frame marker.
- EOF_BYTE, 8'h5A, end-of-frame marker (used only with FWU_FRAMER_EOF_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_data  in  8  payload byte
- in_valid  in  1  payload byte valid
- in_last  in  1  marks final payload byte of packet
- in_ready  out  1  framer can accept payload byte
- tx_data  out  8  byte to transmitter data input
- tx_valid  out  1  byte valid to transmitter
- tx_ready  in  1  transmitter idle/ready
- busy  out  1  high while a frame is being emitted
- frame_done  out  1  one-cycle pulse after final frame byte accepted
- trunc  out  1  one-cycle pulse when packet was cut at MAX_LEN

Behaviour:
- Reset values: in_ready=0 for the reset cycle, then 1. tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, trunc=0. Byte count, read index and checksum are cleared.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when tx_valid && tx_ready.
- tx_ready is the transmitter's idle flag. It drops the cycle after a transfer and rises again after the stop bit. The framer must not assume any fixed byte spacing.
- FSM states: S_FILL, S_SOF, S_LEN, S_PAY, S_CHK, S_EOF (S_EOF only with macro).
- S_FILL:
  - in_ready=1, tx_valid=0.
  - Each accepted byte is written to buf[cnt], then cnt increments and chk += byte (mod 256).
  - The byte is final if in_last=1 or cnt reaches MAX_LEN-1 before the write.
  - If final with in_last=0, pulse trunc the next cycle. The following input bytes start a new packet.
  - On the final byte: next state S_SOF, in_ready=0 from the next cycle.
- S_SOF: tx_data=SOF_BYTE, tx_valid=1. On transfer go to S_LEN.
- S_LEN: tx_data=cnt[7:0]. On transfer go to S_PAY with rd=0.
- S_PAY: tx_data=buf[rd]. On transfer rd increments; when rd==cnt-1 go to S_CHK.
- S_CHK: tx_data=(cnt + sum of payload) mod 256. On transfer go to S_FILL, or S_EOF with the macro.
- Frame end: pulse frame_done the cycle after the final byte transfer. Clear cnt, rd and chk. Set in_ready=1.
- tx_data and tx_valid are registered and held stable while tx_valid=1 && tx_ready=0. tx_valid is never deasserted without a transfer.
- busy=1 in every state except S_FILL.
- A zero-length packet is impossible: in_last always accompanies a byte.
- Input is fully blocked during emission. No overlap of fill and drain.
- Reset mid-frame: next cycle tx_valid=0, the buffered packet is discarded, and the FSM returns to S_FILL. No partial frame resumes.
- Checksum arithmetic is 8-bit wrap-around. LEN equals the number of payload bytes actually buffered, including after truncation.

Optional Feature:
- Macro: FWU_FRAMER_EOF_EN.
- Defined: after CHK, state S_EOF drives tx_data=EOF_BYTE. frame_done pulses after the EOF transfer. Frame length is payload+4.
- Undefined: S_EOF does not exist, EOF_BYTE is unused, and frame_done follows the CHK transfer. Frame length is payload+3.

Test Plan:
- Packet 01,02,03 (last on 03), tx_ready tied 1 -> tx stream A5,03,01,02,03,09; one frame_done pulse; in_ready low from cycle after 03 until after 09.
- Single byte FF with last -> A5,01,FF,00 (checksum wraps); busy high for exactly the frame duration.
- MAX_LEN=4, six bytes 10..15 without last -> first frame A5,04,10,11,12,13,4A; trunc pulses once. After 14,15(last) -> A5,02,14,15,2B.
- Backpressure: tx_ready low for 20 cycles while in S_PAY showing buf[1]=02 -> tx_data stays 02 and tx_valid stays 1; no byte skipped or duplicated after release.
- Real transmitter model (ready low ~10 bit times per byte) with packet of 64 bytes 00..3F -> LEN=40, CHK=(0x40+0x7E0) mod 256=0x20, all bytes in order.
- rst asserted during S_PAY after 2 payload bytes -> tx_valid=0 next cycle; new packet AA(last) then produces clean A5,01,AA,AB. With FWU_FRAMER_EOF_EN, 5A follows.

Source files
------------

// File: rtl/fwu_resp_framer.sv
// Store-and-forward response framer: buffers one packet, then emits SOF, LEN, payload, CHK
// to the UART byte transmitter. Define FWU_FRAMER_EOF_EN to append an EOF byte after CHK.
module fwu_resp_framer #(
    parameter int unsigned MAX_LEN  = 64,
    parameter logic [7:0]  SOF_BYTE = 8'hA5,
    parameter logic [7:0]  EOF_BYTE = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       trunc
);

    localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [2:0] S_FILL = 3'd0;
    localparam logic [2:0] S_SOF  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
`ifdef FWU_FRAMER_EOF_EN
    localparam logic [2:0] S_EOF  = 3'd5;
    localparam logic [2:0] S_LAST = S_EOF;
`else
    localparam logic [2:0] S_LAST = S_CHK;
    // EOF marker is not emitted in this build.
    logic [7:0] unused_eof;
    assign unused_eof = EOF_BYTE;
`endif

    logic [2:0] state;
    logic [7:0] cnt;
    logic [7:0] rd;
    logic [7:0] chk;
    logic [7:0] mem [DEPTH];

    logic       in_fire;
    logic       tx_fire;
    logic       in_final;
    logic       frame_end;
    logic [7:0] rd_nxt;

    assign in_fire   = in_valid && in_ready;
    assign tx_fire   = tx_valid && tx_ready;
    assign in_final  = in_last || (cnt == 8'(MAX_LEN - 1));
    assign frame_end = tx_fire && (state == S_LAST);
    assign rd_nxt    = rd + 8'd1;
    assign busy      = (state != S_FILL);

    // NOTE: the payload buffer is deliberately left out of reset; cnt bounds every read,
    // so stale contents are never emitted and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[cnt[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FILL;
            cnt        <= 8'h00;
            rd         <= 8'h00;
            chk        <= 8'h00;
            in_ready   <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            frame_done <= 1'b0;
            trunc      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            trunc      <= 1'b0;

            case (state)
                S_FILL: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        cnt <= cnt + 8'd1;
                        chk <= chk + in_data;
                        if (in_final) begin
                            // Buffer full without in_last: the remainder becomes a new packet.
                            trunc    <= !in_last;
                            in_ready <= 1'b0;
                            tx_data  <= SOF_BYTE;
                            tx_valid <= 1'b1;
                            state    <= S_SOF;
                        end
                    end
                end
                S_SOF: begin
                    if (tx_fire) begin
                        tx_data <= cnt;
                        state   <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (tx_fire) begin
                        tx_data <= mem[{AW{1'b0}}];
                        rd      <= 8'h00;
                        state   <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (tx_fire) begin
                        if (rd == cnt - 8'd1) begin
                            tx_data <= cnt + chk;
                            state   <= S_CHK;
                        end else begin
                            rd      <= rd_nxt;
                            tx_data <= mem[rd_nxt[AW-1:0]];
                        end
                    end
                end
                S_CHK: begin
`ifdef FWU_FRAMER_EOF_EN
                    if (tx_fire) begin
                        tx_data <= EOF_BYTE;
                        state   <= S_EOF;
                    end
`endif
                end
`ifdef FWU_FRAMER_EOF_EN
                S_EOF: begin
                end
`endif
                default: state <= S_FILL;
            endcase

            // Final frame byte accepted: drop the packet and reopen the input.
            if (frame_end) begin
                state      <= S_FILL;
                tx_valid   <= 1'b0;
                tx_data    <= 8'h00;
                cnt        <= 8'h00;
                rd         <= 8'h00;
                chk        <= 8'h00;
                in_ready   <= 1'b1;
                frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwu_resp_framer.sv
// Bench for fwu_resp_framer: a MAX_LEN=64 and a MAX_LEN=4 instance, each checked every cycle
// against a packet-level model; follows FWU_FRAMER_EOF_EN when it is defined.
module tb_fwu_resp_framer;

    localparam int NU = 2;
    localparam int RB = 4096;
`ifdef FWU_FRAMER_EOF_EN
    localparam int OVH     = 4;
    localparam bit HAS_EOF = 1'b1;
`else
    localparam int OVH     = 3;
    localparam bit HAS_EOF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data    [NU];
    logic       in_valid   [NU];
    logic       in_last    [NU];
    logic       in_ready   [NU];
    logic [7:0] tx_data    [NU];
    logic       tx_valid   [NU];
    logic       tx_ready   [NU];
    logic       busy       [NU];
    logic       frame_done [NU];
    logic       trunc      [NU];

    always #5 clk = ~clk;

    fwu_resp_framer #(.MAX_LEN(64)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .trunc(trunc[0])
    );

    fwu_resp_framer #(.MAX_LEN(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .trunc(trunc[1])
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: partial packet, queue of expected frame bytes, pending pulses.
    logic [7:0] fill_buf [NU][256];
    int         fill_n   [NU] = '{0, 0};
    logic [7:0] exp_buf  [NU][RB];
    bit         exp_end  [NU][RB];
    int         exp_rd   [NU] = '{0, 0};
    int         exp_wr   [NU] = '{0, 0};
    bit         exp_fd   [NU] = '{0, 0};
    bit         exp_tr   [NU] = '{0, 0};
    bit         post_rst [NU] = '{1, 1};
    logic [7:0] log_buf  [NU][RB];
    int         log_n    [NU] = '{0, 0};
    int         busy_cycles [NU] = '{0, 0};
    int         trunc_cnt   [NU] = '{0, 0};
    int         fd_cnt      [NU] = '{0, 0};
    int         tx_mode     [NU] = '{0, 0};
    int         gap         [NU] = '{0, 0};
    logic [7:0] want [$];

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s: got 0x%0h, expected 0x%0h at %0t", u, name, act, exp, $time);
        end
    endtask

    function automatic int max_len_of(input int u);
        return (u == 0) ? 64 : 4;
    endfunction

    task automatic push_byte(input int u, input logic [7:0] b, input bit e);
        exp_buf[u][exp_wr[u] % RB] = b;
        exp_end[u][exp_wr[u] % RB] = e;
        exp_wr[u]++;
    endtask

    task automatic push_frame(input int u);
        int sum = 0;
        push_byte(u, 8'hA5, 1'b0);
        push_byte(u, 8'(fill_n[u]), 1'b0);
        for (int i = 0; i < fill_n[u]; i++) begin
            push_byte(u, fill_buf[u][i], 1'b0);
            sum += int'(fill_buf[u][i]);
        end
        push_byte(u, 8'((fill_n[u] + sum) % 256), !HAS_EOF);
        if (HAS_EOF) push_byte(u, 8'h5A, 1'b1);
    endtask

    // Compare process: check outputs against the model, then apply the transfers of the coming edge.
    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            int pend;
            pend = exp_wr[u] - exp_rd[u];
            if (busy[u] === 1'b1) busy_cycles[u]++;
            if (trunc[u] === 1'b1) trunc_cnt[u]++;
            if (frame_done[u] === 1'b1) fd_cnt[u]++;
            if (chk_en) begin
                check("tx_valid", u, 32'(tx_valid[u]), 32'(pend > 0));
                if (pend > 0) check("tx_data", u, 32'(tx_data[u]), 32'(exp_buf[u][exp_rd[u] % RB]));
                check("busy", u, 32'(busy[u]), 32'(pend > 0));
                check("in_ready", u, 32'(in_ready[u]), 32'(pend == 0 && !post_rst[u]));
                check("frame_done", u, 32'(frame_done[u]), 32'(exp_fd[u]));
                check("trunc", u, 32'(trunc[u]), 32'(exp_tr[u]));
            end
            if (rst) begin
                fill_n[u]   = 0;
                exp_rd[u]   = exp_wr[u];
                exp_fd[u]   = 1'b0;
                exp_tr[u]   = 1'b0;
                post_rst[u] = 1'b1;
            end else begin
                post_rst[u] = 1'b0;
                exp_fd[u]   = 1'b0;
                exp_tr[u]   = 1'b0;
                if (tx_valid[u] && tx_ready[u]) begin
                    log_buf[u][log_n[u] % RB] = tx_data[u];
                    log_n[u]++;
                    if (pend > 0) begin
                        exp_fd[u] = exp_end[u][exp_rd[u] % RB];
                        exp_rd[u]++;
                    end
                end
                if (in_valid[u] && in_ready[u]) begin
                    fill_buf[u][fill_n[u]] = in_data[u];
                    fill_n[u]++;
                    if (in_last[u] || fill_n[u] == max_len_of(u)) begin
                        push_frame(u);
                        exp_tr[u] = !in_last[u];
                        fill_n[u] = 0;
                    end
                end
            end
        end
    end

    // Transmitter model: 0 always ready, 1 random, 2 UART-like (busy 12 cycles per byte), 3 stalled.
    always @(posedge clk) begin : tx_drv
        bit xf [NU];
        for (int u = 0; u < NU; u++) xf[u] = tx_valid[u] && tx_ready[u];
        #1;
        for (int u = 0; u < NU; u++) begin
            if (xf[u]) gap[u] = 12;
            else if (gap[u] > 0) gap[u]--;
            case (tx_mode[u])
                0:       tx_ready[u] = 1'b1;
                1:       tx_ready[u] = 1'($urandom_range(0, 1));
                2:       tx_ready[u] = (gap[u] == 0);
                default: tx_ready[u] = 1'b0;
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input int u, input logic [7:0] d, input logic l);
        int t = 0;
        bit done = 1'b0;
        in_data[u]  = d;
        in_valid[u] = 1'b1;
        in_last[u]  = l;
        while (!done && t < 5000) begin
            @(posedge clk);
            done = in_ready[u];
            t++;
        end
        #1;
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
        check("input accepted", u, 32'(done), 32'd1);
    endtask

    task automatic send_packet(input int u, input logic [7:0] p [256], input int len,
                               input bit last_end, input int max_gap);
        for (int i = 0; i < len; i++) begin
            send_byte(u, p[i], last_end && (i == len - 1));
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic wait_idle(input int u);
        int t = 0;
        while ((busy[u] || exp_wr[u] != exp_rd[u]) && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("frame drained", u, 32'(t < 20000), 32'd1);
        idle(2);
    endtask

    task automatic check_log(input int u, input int base);
        check("frame length", u, 32'(log_n[u] - base), 32'(want.size()));
        for (int i = 0; i < want.size(); i++)
            check($sformatf("frame byte %0d", i), u, 32'(log_buf[u][(base + i) % RB]), 32'(want[i]));
    endtask

    task automatic rand_traffic(input int u, input int npkt, input int maxlen);
        logic [7:0] p [256];
        for (int k = 0; k < npkt; k++) begin
            int len;
            len = $urandom_range(1, maxlen);
            for (int i = 0; i < len; i++) p[i] = 8'($urandom);
            tx_mode[u] = int'($urandom_range(0, 1));
            send_packet(u, p, len, 1'b1, 2);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
        end
        wait_idle(u);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] p [256];
        int base, snap_a, snap_b, t;
        bit seen;

        for (int u = 0; u < NU; u++) begin
            in_data[u]  = 8'h00;
            in_valid[u] = 1'b0;
            in_last[u]  = 1'b0;
            tx_ready[u] = 1'b1;
        end

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            check("reset tx_valid", u, 32'(tx_valid[u]), 32'd0);
            check("reset tx_data", u, 32'(tx_data[u]), 32'h00);
            check("reset busy", u, 32'(busy[u]), 32'd0);
            check("reset frame_done", u, 32'(frame_done[u]), 32'd0);
            check("reset trunc", u, 32'(trunc[u]), 32'd0);
            check("reset in_ready", u, 32'(in_ready[u]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(1);
        check("in_ready after reset", 0, 32'(in_ready[0]), 32'd1);

        // 01,02,03 with transmitter always ready.
        base = log_n[0];
        snap_a = fd_cnt[0];
        p[0] = 8'h01; p[1] = 8'h02; p[2] = 8'h03;
        send_packet(0, p, 3, 1'b1, 0);
        wait_idle(0);
        want = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        if (HAS_EOF) want.push_back(8'h5A);
        check_log(0, base);
        check("frame_done pulses", 0, 32'(fd_cnt[0] - snap_a), 32'd1);

        // Single FF: checksum wraps; busy lasts exactly one frame.
        base = log_n[0];
        snap_a = busy_cycles[0];
        p[0] = 8'hFF;
        send_packet(0, p, 1, 1'b1, 0);
        wait_idle(0);
        want = '{8'hA5, 8'h01, 8'hFF, 8'h00};
        if (HAS_EOF) want.push_back(8'h5A);
        check_log(0, base);
        check("busy cycles", 0, 32'(busy_cycles[0] - snap_a), 32'(OVH + 1));

        // MAX_LEN=4 instance: six bytes, last only on the sixth.
        base = log_n[1];
        snap_a = trunc_cnt[1];
        snap_b = fd_cnt[1];
        for (int i = 0; i < 6; i++) p[i] = 8'(8'h10 + i);
        send_packet(1, p, 6, 1'b1, 0);
        wait_idle(1);
        want = '{8'hA5, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h4A};
        if (HAS_EOF) want.push_back(8'h5A);
        want.push_back(8'hA5); want.push_back(8'h02); want.push_back(8'h14);
        want.push_back(8'h15); want.push_back(8'h2B);
        if (HAS_EOF) want.push_back(8'h5A);
        check_log(1, base);
        check("trunc pulses", 1, 32'(trunc_cnt[1] - snap_a), 32'd1);
        check("frame_done pulses", 1, 32'(fd_cnt[1] - snap_b), 32'd2);

        // Backpressure: stall 20 cycles while payload byte 02 is presented.
        tx_mode[0] = 2;
        base = log_n[0];
        p[0] = 8'h01; p[1] = 8'h02; p[2] = 8'h03;
        send_packet(0, p, 3, 1'b1, 0);
        seen = 1'b0;
        t = 0;
        while (!seen && t < 2000) begin
            @(negedge clk);
            seen = tx_valid[0] && (tx_data[0] == 8'h02) && !tx_ready[0];
            t++;
        end
        check("reached payload byte 02", 0, 32'(seen), 32'd1);
        tx_mode[0] = 3;
        repeat (20) begin
            @(negedge clk);
            check("stall tx_valid", 0, 32'(tx_valid[0]), 32'd1);
            check("stall tx_data", 0, 32'(tx_data[0]), 32'h02);
        end
        tx_mode[0] = 0;
        wait_idle(0);
        want = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        if (HAS_EOF) want.push_back(8'h5A);
        check_log(0, base);

        // UART-paced 64-byte packet 00..3F.
        tx_mode[0] = 2;
        base = log_n[0];
        snap_a = trunc_cnt[0];
        for (int i = 0; i < 64; i++) p[i] = 8'(i);
        send_packet(0, p, 64, 1'b1, 0);
        wait_idle(0);
        want = '{8'hA5, 8'h40};
        for (int i = 0; i < 64; i++) want.push_back(8'(i));
        want.push_back(8'h20);
        if (HAS_EOF) want.push_back(8'h5A);
        check_log(0, base);
        check("no trunc at exact MAX_LEN", 0, 32'(trunc_cnt[0] - snap_a), 32'd0);

        // Reset during payload emission after two payload bytes.
        base = log_n[0];
        p[0] = 8'h11; p[1] = 8'h22; p[2] = 8'h33; p[3] = 8'h44;
        send_packet(0, p, 4, 1'b1, 0);
        t = 0;
        while (log_n[0] - base < 4 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reached mid payload", 0, 32'(log_n[0] - base), 32'd4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid-frame reset tx_valid", 0, 32'(tx_valid[0]), 32'd0);
        check("mid-frame reset tx_data", 0, 32'(tx_data[0]), 32'h00);
        check("mid-frame reset busy", 0, 32'(busy[0]), 32'd0);
        idle(1);
        base = log_n[0];
        p[0] = 8'hAA;
        send_packet(0, p, 1, 1'b1, 0);
        wait_idle(0);
        want = '{8'hA5, 8'h01, 8'hAA, 8'hAB};
        if (HAS_EOF) want.push_back(8'h5A);
        check_log(0, base);

        // Randomised packets on both instances, including truncation on each.
        fork
            rand_traffic(0, 30, 70);
            rand_traffic(1, 40, 9);
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
